// File: rtl/fp16_div.sv
// Iterative fp16 divider (restoring, 1 quotient bit/cycle), FTZ on inputs and outputs.
// Define FP16_DIV_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp16_div #(
  parameter int          EXP_BIAS  = 15,
  parameter logic [15:0] NAN_VALUE = 16'h7E00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
);

`ifdef FP16_DIV_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               sign;
  logic signed [6:0]  exp_q;
  logic [10:0]        divisor;
  logic [11:0]        rem;
  logic [12:0]        quo;

  // operand classification
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic spec_nan, spec_inf, spec_zero, in_sign;
  logic signed [6:0] e_init;

  always_comb begin
    a_zero    = (a[14:10] == 5'd0);
    b_zero    = (b[14:10] == 5'd0);
    a_inf     = (&a[14:10]) & ~(|a[9:0]);
    b_inf     = (&b[14:10]) & ~(|b[9:0]);
    a_nan     = (&a[14:10]) &  (|a[9:0]);
    b_nan     = (&b[14:10]) &  (|b[9:0]);
    spec_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    spec_inf  = b_zero | a_inf;
    spec_zero = a_zero | b_inf;
    in_sign   = a[15] ^ b[15];
    e_init    = $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]}) + $signed(EXP_BIAS[6:0]);
  end

  // one restoring step
  logic        rem_ge;
  logic [11:0] rem_sub;

  always_comb begin
    rem_ge  = (rem >= {1'b0, divisor});
    rem_sub = rem_ge ? (rem - {1'b0, divisor}) : rem;
  end

  // normalize / round / range-check
  logic [9:0]        mant, mant_f;
  logic              guard, sticky, inc;
  logic [10:0]       mant_r;
  logic signed [6:0] e_n, e_f;
  logic [15:0]       norm_res;

  always_comb begin
    if (quo[12]) begin
      mant   = quo[11:2];
      guard  = quo[1];
      sticky = quo[0] | (|rem);
      e_n    = exp_q;
    end else begin
      mant   = quo[10:1];
      guard  = quo[0];
      sticky = |rem;
      e_n    = exp_q - 7'sd1;
    end
    inc    = RNE & guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {10'd0, inc};
    if (mant_r[10]) begin
      mant_f = 10'd0;
      e_f    = e_n + 7'sd1;
    end else begin
      mant_f = mant_r[9:0];
      e_f    = e_n;
    end
    if (e_f >= 7'sd31)     norm_res = {sign, 5'h1F, 10'h000};
    else if (e_f <= 7'sd0) norm_res = {sign, 15'h0000};
    else                   norm_res = {sign, e_f[4:0], mant_f};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 16'h0000;
      cnt       <= 4'd0;
      sign      <= 1'b0;
      exp_q     <= 7'sd0;
      divisor   <= 11'd0;
      rem       <= 12'd0;
      quo       <= 13'd0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          sign     <= in_sign;
          if (spec_nan || spec_inf || spec_zero) begin
            if (spec_nan)      result <= NAN_VALUE;
            else if (spec_inf) result <= {in_sign, 5'h1F, 10'h000};
            else               result <= {in_sign, 15'h0000};
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            divisor <= {1'b1, b[9:0]};
            rem     <= {2'b01, a[9:0]};
            quo     <= 13'd0;
            cnt     <= 4'd0;
            exp_q   <= e_init;
            state   <= S_DIV;
          end
        end
        S_DIV: begin
          quo <= {quo[11:0], rem_ge};
          rem <= {rem_sub[10:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd12) state <= S_NORM;
        end
        S_NORM: begin
          result    <= norm_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div.sv
// Directed-vector bench for fp16_div: table of operand pairs plus stall and abort sequences.
module tb_fp16_div;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;

  int checks = 0;
  int failures = 0;

  fp16_div dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] exp_res;
    int          exp_lat;
    string       name;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Issue one op with out_ready high; measure edges from the accepting edge (inclusive) to out_valid.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                       input logic [15:0] exp_res, input int exp_lat, input string nm);
    int  lat;
    int  k;
    bit  rdy_seen;
    @(negedge clk);
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_res"}, {16'd0, result}, {16'd0, exp_res});
    chk({nm, "_busy"}, {31'd0, rdy_seen | in_ready}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_hs"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'h4200, 16'h3E00, 16'h4000, 15, "3p0_div_1p5"});
    vecs.push_back('{16'h3E00, 16'h3E80, 16'h3B62, 15, "1p5_div_1p625"});
    vecs.push_back('{16'h3C00, 16'h4200, 16'h3555, 15, "1_div_3"});
    vecs.push_back('{16'hC600, 16'h4000, 16'hC200, 15, "neg6_div_2"});
    vecs.push_back('{16'hBC00, 16'hBC00, 16'h3C00, 15, "neg1_div_neg1"});
    vecs.push_back('{16'h7BFF, 16'h0400, 16'h7C00, 15, "overflow"});
    vecs.push_back('{16'h0400, 16'h7BFF, 16'h0000, 15, "underflow"});
    vecs.push_back('{16'h3C00, 16'h0000, 16'h7C00, 1,  "x_div_0"});
    vecs.push_back('{16'h0000, 16'h0000, 16'h7E00, 1,  "0_div_0"});
    vecs.push_back('{16'h7C01, 16'h3C00, 16'h7E00, 1,  "nan_a"});
    vecs.push_back('{16'h3C00, 16'hFE00, 16'h7E00, 1,  "nan_b"});
    vecs.push_back('{16'h7C00, 16'hFC00, 16'h7E00, 1,  "inf_div_inf"});
    vecs.push_back('{16'hFC00, 16'h4000, 16'hFC00, 1,  "inf_div_x"});
    vecs.push_back('{16'h4000, 16'hFC00, 16'h8000, 1,  "x_div_inf"});
    vecs.push_back('{16'h8000, 16'h4500, 16'h8000, 1,  "negzero_div_x"});
    vecs.push_back('{16'h0001, 16'h3C00, 16'h0000, 1,  "sub_a_ftz"});
    vecs.push_back('{16'h3C00, 16'h8001, 16'hFC00, 1,  "sub_b_ftz"});

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_state", {14'd0, in_ready, out_valid, result}, {14'd0, 1'b1, 1'b0, 16'h0000});
    @(negedge clk); reset_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i].va, vecs[i].vb, vecs[i].exp_res, vecs[i].exp_lat, vecs[i].name);

    // Stall in S_DONE: output must hold and new operands must be ignored.
    begin
      int k;
      @(negedge clk);
      a = 16'h4200; b = 16'h3E00; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      chk("stall_reach_done", {31'd0, out_valid}, 32'd1);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        a = 16'h3C00; b = 16'h0000; in_valid = 1'b1;
        chk("stall_hold", {14'd0, out_valid, in_ready, result}, {14'd0, 1'b1, 1'b0, 16'h4000});
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release", {30'd0, in_ready, out_valid}, 32'd2);
    end

    // Abort mid-division, then a clean op with normal latency.
    begin
      @(negedge clk);
      a = 16'h4200; b = 16'h3E00; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_state", {14'd0, in_ready, out_valid, result}, {14'd0, 1'b1, 1'b0, 16'h0000});
      @(negedge clk); reset_n = 1'b1;
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid) chk("abort_no_output", {31'd0, out_valid}, 32'd0);
      end
      do_op(16'h4400, 16'h4000, 16'h4000, 15, "post_abort");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
